// File: rtl/lsu_pkg.sv
// Shared types and default sizing for the LSU store buffer.
package lsu_pkg;

  localparam int LSU_DATA_WIDTH = 32;
  localparam int LSU_ADDR_WIDTH = 32;
  localparam int LSU_STB_DEPTH  = 4;

  typedef enum logic [1:0] {
    DRN_IDLE  = 2'd0,
    DRN_WRITE = 2'd1,
    DRN_GAP   = 2'd2
  } drain_state_e;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/lsu_store_buffer_if.sv
// Pipeline request/response and data-memory port signals of the LSU store buffer.
interface lsu_store_buffer_if
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = LSU_DATA_WIDTH,
  parameter int ADDR_WIDTH = LSU_ADDR_WIDTH
);

  logic                  lsu_st_valid;
  logic                  lsu_ld_valid;
  logic [ADDR_WIDTH-1:0] lsu_addr;
  logic [DATA_WIDTH-1:0] lsu_wr_data;
  logic [DATA_WIDTH-1:0] lsu_rd_data;
  logic                  lsu_stall;
  logic                  mem_wr_en;
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  mem_ready;

  modport slave (
    input  lsu_st_valid, lsu_ld_valid, lsu_addr, lsu_wr_data, mem_rd_data, mem_ready,
    output lsu_rd_data, lsu_stall, mem_wr_en, mem_rd_en, mem_addr, mem_wr_data
  );

  modport master (
    output lsu_st_valid, lsu_ld_valid, lsu_addr, lsu_wr_data, mem_rd_data, mem_ready,
    input  lsu_rd_data, lsu_stall, mem_wr_en, mem_rd_en, mem_addr, mem_wr_data
  );

endinterface

// File: rtl/lsu_stb_fifo.sv
// Circular store buffer with occupancy count, head-entry outputs and youngest-match forwarding.
module lsu_stb_fifo
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = LSU_DATA_WIDTH,
  parameter int ADDR_WIDTH = LSU_ADDR_WIDTH,
  parameter int DEPTH      = LSU_STB_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] hit_data
);

  localparam int PW = ptr_width(DEPTH);

  logic [DEPTH-1:0]      valid;
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [PW:0]           count;
  logic [PW-1:0]         idx;

  // push never targets a full buffer and pop never an empty one, so head != tail when both fire
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        valid[tail]    <= 1'b1;
        addr_mem[tail] <= push_addr;
        data_mem[tail] <= push_data;
        tail           <= tail + 1'b1;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign full      = (count == (PW+1)'(DEPTH));
  assign empty     = (count == '0);
  assign head_addr = addr_mem[head];
  assign head_data = data_mem[head];

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (valid[idx] && (addr_mem[idx] == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = data_mem[idx];
      end
    end
  end

endmodule

// File: rtl/lsu_store_buffer.sv
// LSU top: drain FSM moving buffered stores to a multi-cycle memory, port mux and stall logic.
// state | meaning
// IDLE  | port free for loads; start a drain when the buffer holds an entry
// WRITE | head entry presented to memory until write-done
// GAP   | one write-free cycle that guarantees a load slot
module lsu_store_buffer
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = LSU_DATA_WIDTH,
  parameter int ADDR_WIDTH = LSU_ADDR_WIDTH,
  parameter int STB_DEPTH  = LSU_STB_DEPTH
) (
  input logic               clk,
  input logic               reset,
  lsu_store_buffer_if.slave bus
);

  drain_state_e          state_q;
  drain_state_e          state_d;
  logic                  first_cyc_q;
  logic                  first_cyc_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q;
  logic [DATA_WIDTH-1:0] wdata_hold_q;

  logic                  push;
  logic                  pop;
  logic                  wr_active;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  fwd_hit;
  logic [DATA_WIDTH-1:0] fwd_data;

  logic                  req_conflict;
  logic                  ld_miss;
  logic                  rd_port;

  lsu_stb_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (STB_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_addr   (bus.lsu_addr),
    .push_data   (bus.lsu_wr_data),
    .pop         (pop),
    .lookup_addr (bus.lsu_addr),
    .full        (full),
    .empty       (empty),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .hit         (fwd_hit),
    .hit_data    (fwd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= DRN_IDLE;
      first_cyc_q  <= 1'b0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else begin
      state_q      <= state_d;
      first_cyc_q  <= first_cyc_d;
      addr_hold_q  <= bus.mem_addr;
      wdata_hold_q <= bus.mem_wr_data;
    end
  end

  // mem_ready is stale on the first WRITE cycle, so completion waits for first_cyc to clear.
  always_comb begin
    state_d     = state_q;
    first_cyc_d = first_cyc_q;
    pop         = 1'b0;
    wr_active   = 1'b0;
    case (state_q)
      DRN_IDLE: begin
        if (!empty) begin
          state_d     = DRN_WRITE;
          first_cyc_d = 1'b1;
        end
      end
      DRN_WRITE: begin
        wr_active   = 1'b1;
        first_cyc_d = 1'b0;
        if (bus.mem_ready && !first_cyc_q) begin
          pop     = 1'b1;
          state_d = DRN_GAP;
        end
      end
      DRN_GAP: begin
        state_d = DRN_IDLE;
      end
      default: begin
        state_d     = DRN_IDLE;
        first_cyc_d = 1'b0;
      end
    endcase
  end

  // A full buffer stalls a store even when the head retires this same cycle.
  assign req_conflict = bus.lsu_st_valid && bus.lsu_ld_valid;
  assign ld_miss      = bus.lsu_ld_valid && !fwd_hit;
  assign rd_port      = ld_miss && !wr_active && !req_conflict;

  assign bus.lsu_stall   = req_conflict
                         || (ld_miss && wr_active)
                         || (bus.lsu_st_valid && full);
  assign push            = bus.lsu_st_valid && !bus.lsu_stall;

  assign bus.mem_wr_en   = wr_active;
  assign bus.mem_rd_en   = rd_port;
  assign bus.mem_addr    = wr_active ? head_addr :
                           rd_port   ? bus.lsu_addr : addr_hold_q;
  assign bus.mem_wr_data = wr_active ? head_data : wdata_hold_q;
  assign bus.lsu_rd_data = fwd_hit ? fwd_data : bus.mem_rd_data;

endmodule
